// File: rtl/mire_frame_writer.sv
// Avalon-MM burst-write master that fills the framebuffer with a generated test frame.
// Word order, burst size and address map mirror the VGA scan-out reader.
module mire_frame_writer #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned BURSTSIZE = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         loop,
  input  logic [1:0]                   pattern,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  frame_count,
  output logic [31:0]                  avm_address,
  output logic                         avm_write,
  output logic [31:0]                  avm_writedata,
  output logic [3:0]                   avm_byteenable,
  output logic [$clog2(BURSTSIZE):0]   avm_burstcount,
  output logic                         avm_read,
  input  logic                         avm_waitrequest
);

  localparam int unsigned XW  = $clog2(HDISP);
  localparam int unsigned YW  = $clog2(VDISP);
  localparam int unsigned BW  = ($clog2(BURSTSIZE) > 0) ? $clog2(BURSTSIZE) : 1;
  localparam int unsigned CW  = $clog2(BURSTSIZE) + 1;
  localparam logic [31:0] BURST_BYTES = 32'(4 * BURSTSIZE);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      pat_q, pat_d;
  logic            done_q, done_d;
  logic [15:0]     fcnt_q, fcnt_d;

  // Pixel generator: 0 grid, 1 grey ramp, 2 black, 3 white (0x00RRGGBB).
  function automatic logic [31:0] pixel(input logic [1:0] p,
                                        input logic [XW-1:0] px,
                                        input logic [YW-1:0] py);
    logic [7:0] xb;
    xb = 8'(px);
    case (p)
      2'd0:    pixel = ((4'(px) == 4'hF) || (4'(py) == 4'hF)) ? 32'h00FF_FFFF : 32'h0;
      2'd1:    pixel = {8'h00, xb, xb, xb};
      2'd2:    pixel = 32'h0;
      default: pixel = 32'h00FF_FFFF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      beat_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          pat_d   = pattern;
          addr_d  = BASE_ADDR;
          x_d     = '0;
          y_d     = '0;
          beat_d  = '0;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (x_q == XW'(HDISP - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (beat_q == BW'(BURSTSIZE - 1)) begin
            beat_d = '0;
            addr_d = addr_q + BURST_BYTES;
          end else begin
            beat_d = beat_q + BW'(1);
          end
          // Final beat of the frame always closes a burst, so the address restarts cleanly.
          if ((x_q == XW'(HDISP - 1)) && (y_q == YW'(VDISP - 1))) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
            x_d    = '0;
            y_d    = '0;
            beat_d = '0;
            addr_d = BASE_ADDR;
            if (loop) begin
              pat_d = pattern;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wdata_d = pixel(pat_d, x_d, y_d);
  end

  assign avm_write      = (state_q == WRITE);
  assign busy           = (state_q == WRITE);
  assign done           = done_q;
  assign frame_count    = fcnt_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign avm_burstcount = CW'(BURSTSIZE);
  assign avm_read       = 1'b0;

endmodule

// File: tb/tb_mire_frame_writer.sv
// Scoreboard bench for mire_frame_writer: a frame-level reference model queues expected
// beats, a negedge monitor pops and compares every accepted beat.
module tb_mire_frame_writer;

  localparam int unsigned H    = 32;
  localparam int unsigned V    = 4;
  localparam int unsigned BS   = 16;
  localparam logic [31:0] BASE = 32'h1000;
  localparam int unsigned NPIX = H * V;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        loop;
  logic [1:0]  pattern;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [4:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_waitrequest;

  mire_frame_writer #(.HDISP(H), .VDISP(V), .BURSTSIZE(BS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .loop(loop), .pattern(pattern),
    .busy(busy), .done(done), .frame_count(frame_count),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nerr = 0;
  int          beats_seen = 0;
  int          done_seen = 0;
  logic [63:0] sb[$];
  bit          stall_en = 0;
  bit          tog_en = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    ncmp++;
    nerr++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference frame: pixel i is at x=i%H, y=i/H; burst k covers pixels k*BS..k*BS+BS-1.
  function automatic logic [31:0] ref_pix(input int p, input int i);
    int x, y;
    logic [7:0] g;
    x = i % H;
    y = i / H;
    g = 8'(x % 256);
    case (p)
      0:       return ((x % 16 == 15) || (y % 16 == 15)) ? 32'h00FF_FFFF : 32'h0;
      1:       return {8'h00, g, g, g};
      2:       return 32'h0;
      default: return 32'h00FF_FFFF;
    endcase
  endfunction

  function automatic void push_frame(input int p);
    for (int i = 0; i < int'(NPIX); i++)
      sb.push_back({BASE + 32'((i / BS) * BS * 4), ref_pix(p, i)});
  endfunction

  // Monitor: every accepted beat is checked against the scoreboard; stalls must hold outputs.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (done) done_seen <= done_seen + 1;
      if (avm_write && prev_stall) begin
        chk("hold_addr", avm_address, prev_addr);
        chk("hold_data", avm_writedata, prev_data);
      end
      if (avm_write && !avm_waitrequest) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = sb.pop_front();
          chk("beat_addr", avm_address, e[63:32]);
          chk("beat_data", avm_writedata, e[31:0]);
          beats_seen <= beats_seen + 1;
        end
      end
      prev_stall <= avm_write && avm_waitrequest;
      prev_addr  <= avm_address;
      prev_data  <= avm_writedata;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (tog_en) pattern = 2'($urandom);
  endtask

  task automatic pulse_start(input logic [1:0] p);
    pattern = p;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
  endtask

  // Counts cycles with avm_write high up to and including the done cycle.
  task automatic wait_done(input int maxc, output int wc, output bit got);
    wc  = avm_write ? 1 : 0;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (avm_write) wc++;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("done_timeout");
  endtask

  task automatic settle_and_check(input int exp_fc, input int exp_done);
    cycle();
    cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    chk("done_pulses", 32'(done_seen), 32'(exp_done));
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int  wc;
    bit  got;
    int  exp_fc;
    int  exp_done;
    int  base;

    reset_n = 1'b0;
    start = 1'b0;
    loop = 1'b0;
    pattern = 2'd0;
    avm_waitrequest = 1'b0;
    exp_fc = 0;
    exp_done = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
      loop = 1'($urandom);
      pattern = 2'($urandom);
      avm_waitrequest = 1'($urandom);
      #3;
      chk("rst_write", 32'(avm_write), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fcnt", 32'(frame_count), 32'd0);
      chk("rst_addr", avm_address, BASE);
      chk("rst_data", avm_writedata, 32'd0);
      chk("rst_be", 32'(avm_byteenable), 32'hF);
      chk("rst_bcnt", 32'(avm_burstcount), 32'd16);
      chk("rst_read", 32'(avm_read), 32'd0);
    end
    start = 1'b0;
    loop = 1'b0;
    avm_waitrequest = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();

    // Grid frame, no stalls: exactly NPIX back-to-back beats.
    push_frame(0);
    pulse_start(2'd0);
    chk("first_addr", avm_address, BASE);
    chk("first_busy", 32'(busy), 32'd1);
    wait_done(1000, wc, got);
    chk("grid_write_cycles", 32'(wc), 32'(NPIX));
    exp_fc++; exp_done++;
    settle_and_check(exp_fc, exp_done);

    // Grid frame with ~50% waitrequest.
    stall_en = 1;
    push_frame(0);
    pulse_start(2'd0);
    wait_done(2000, wc, got);
    stall_en = 0;
    exp_fc++; exp_done++;
    settle_and_check(exp_fc, exp_done);

    // Grey ramp with pattern toggled mid-frame and random stalls.
    push_frame(1);
    pulse_start(2'd1);
    tog_en = 1;
    stall_en = 1;
    wait_done(2000, wc, got);
    tog_en = 0;
    stall_en = 0;
    exp_fc++; exp_done++;
    settle_and_check(exp_fc, exp_done);

    // Loop: pattern re-latched at frame end, no idle cycle, then loop dropped.
    loop = 1'b1;
    push_frame(0);
    push_frame(1);
    pulse_start(2'd0);
    pattern = 2'd1;
    wait_done(1000, wc, got);
    exp_fc++; exp_done++;
    chk("loop_write_cycles", 32'(wc), 32'(NPIX + 1));
    chk("loop_busy_at_done", 32'(busy), 32'd1);
    chk("loop_addr_restart", avm_address, BASE);
    chk("loop_fcnt_mid", 32'(frame_count), 32'(exp_fc));
    loop = 1'b0;
    wait_done(1000, wc, got);
    exp_fc++; exp_done++;
    chk("loop_end_write", 32'(avm_write), 32'd0);
    settle_and_check(exp_fc, exp_done);

    // Start while busy is ignored, then reset around beat 40.
    push_frame(0);
    base = beats_seen;
    pulse_start(2'd0);
    for (int i = 0; i < 10; i++) cycle();
    pulse_start(2'd3);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (beats_seen - base >= 40) begin
        got = 1;
        break;
      end
      cycle();
    end
    if (!got) fail_now("beat40_timeout");
    reset_n = 1'b0;
    #1;
    chk("async_write_low", 32'(avm_write), 32'd0);
    chk("async_busy_low", 32'(busy), 32'd0);
    sb.delete();
    exp_fc = 0;
    cycle();
    cycle();
    chk("mid_rst_fcnt", 32'(frame_count), 32'd0);
    chk("mid_rst_addr", avm_address, BASE);
    reset_n = 1'b1;
    cycle();
    push_frame(0);
    pulse_start(2'd0);
    chk("restart_addr", avm_address, BASE);
    chk("restart_data", avm_writedata, 32'd0);
    wait_done(1000, wc, got);
    exp_fc++; exp_done++;
    settle_and_check(exp_fc, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
